// File: rtl/ethernet_rx_frame_filter_pkg.sv
// Shared constants, header field positions and FSM encoding for the RX frame filter.
// Field positions are beat index plus LSB within a 64-bit beat (byte 0 in [63:56]).
package rx_filter_pkg;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
   localparam logic [47:0] BCAST_MAC      = '1;

   localparam int unsigned HDR_BEATS = 6;
   localparam int unsigned IDX_W     = 3;

   localparam int unsigned MAC_BEAT   = 0;
   localparam int unsigned MAC_LSB    = 16;
   localparam int unsigned ETYPE_BEAT = 1;
   localparam int unsigned ETYPE_LSB  = 16;
   localparam int unsigned VER_BEAT   = 1;
   localparam int unsigned VER_LSB    = 8;
   localparam int unsigned PROTO_BEAT = 2;
   localparam int unsigned PROTO_LSB  = 0;
   localparam int unsigned PORT_BEAT  = 4;
   localparam int unsigned PORT_LSB   = 16;

   typedef enum logic [2:0] {
      ST_CAPTURE,
      ST_DECIDE,
      ST_REPLAY,
      ST_PASS,
      ST_DROP
   } state_t;

endpackage

// File: rtl/ethernet_rx_frame_filter_hdr_check.sv
// Combinational Eth/IPv4/UDP header validation over the buffered header beats.
module rx_hdr_check
   import rx_filter_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter logic [15:0] UDP_DST_PORT = 16'd4791
) (
   input  logic [63:0] hdr [HDR_BEATS],
   output logic        mac_ok,
   output logic        type_ok,
   output logic        ver_ok,
   output logic        proto_ok,
   output logic        port_ok,
   output logic        pass
);

   logic [47:0] dst_mac;
   logic        unused_hdr_bits;

   assign dst_mac  = hdr[MAC_BEAT][MAC_LSB +: 48];
   assign mac_ok   = (dst_mac == LOCAL_MAC) || (ACCEPT_BCAST && (dst_mac == BCAST_MAC));
   assign type_ok  = hdr[ETYPE_BEAT][ETYPE_LSB +: 16] == ETHERTYPE_IPV4;
   assign ver_ok   = hdr[VER_BEAT][VER_LSB +: 8] == IP_VER_IHL;
   assign proto_ok = hdr[PROTO_BEAT][PROTO_LSB +: 8] == IP_PROTO_UDP;
   assign port_ok  = hdr[PORT_BEAT][PORT_LSB +: 16] == UDP_DST_PORT;
   assign pass     = mac_ok && type_ok && ver_ok && proto_ok && port_ok;

   // Payload bytes inside the header window are not inspected.
   assign unused_hdr_bits = ^{hdr[0][15:0], hdr[1][63:32], hdr[1][7:0], hdr[2][63:8],
                              hdr[3], hdr[4][63:32], hdr[4][15:0], hdr[5]};

endmodule

// File: rtl/ethernet_rx_frame_filter.sv
// Store-and-check RX filter: buffers 6 header beats, replays accepted frames, discards the rest.
// Optional statistics counters enabled by defining RX_FILTER_STATS_EN.
module ethernet_rx_frame_filter
   import rx_filter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter logic [15:0] UDP_DST_PORT = 16'd4791
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [31:0]             rx_pass_count,
   output logic [31:0]             rx_drop_count,
   output logic [31:0]             rx_runt_count
);

   localparam logic [IDX_W-1:0] LAST_HDR_IDX = IDX_W'(HDR_BEATS - 1);
   localparam logic [IDX_W-1:0] REPLAY_DONE  = IDX_W'(HDR_BEATS);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;

   logic [DATA_WIDTH-1:0]   hdr_data_q [HDR_BEATS];
   logic [DATA_WIDTH/8-1:0] hdr_keep_q [HDR_BEATS];
   logic                    hdr_last_q [HDR_BEATS];

   logic [DATA_WIDTH-1:0]   m_data_q;
   logic [DATA_WIDTH/8-1:0] m_keep_q;
   logic                    m_valid_q, m_last_q;

   logic s_ready_c, out_free, cap_we, load_replay, load_pass;
   logic runt_inc, drop_inc, pass_inc, hdr_pass;
   logic [4:0] unused_field_ok;

   rx_hdr_check #(
      .LOCAL_MAC    (LOCAL_MAC),
      .ACCEPT_BCAST (ACCEPT_BCAST),
      .UDP_DST_PORT (UDP_DST_PORT)
   ) u_hdr_check (
      .hdr      (hdr_data_q),
      .mac_ok   (unused_field_ok[0]),
      .type_ok  (unused_field_ok[1]),
      .ver_ok   (unused_field_ok[2]),
      .proto_ok (unused_field_ok[3]),
      .port_ok  (unused_field_ok[4]),
      .pass     (hdr_pass)
   );

   // The output register keeps draining in every state, so a previous frame's tail
   // may still be waiting while the next frame is being captured.
   assign out_free = !m_valid_q || m_axis_tready;
   assign pass_inc = m_valid_q && m_axis_tready && m_last_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      s_ready_c   = 1'b0;
      cap_we      = 1'b0;
      load_replay = 1'b0;
      load_pass   = 1'b0;
      runt_inc    = 1'b0;
      drop_inc    = 1'b0;
      case (state_q)
         ST_CAPTURE: begin
            s_ready_c = 1'b1;
            if (s_axis_tvalid) begin
               cap_we = 1'b1;
               if (idx_q == LAST_HDR_IDX) begin
                  state_d = ST_DECIDE;
               end else if (s_axis_tlast) begin
                  runt_inc = 1'b1;
                  idx_d    = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_DECIDE: begin
            idx_d = '0;
            if (hdr_pass) begin
               state_d = ST_REPLAY;
            end else begin
               drop_inc = 1'b1;
               state_d  = hdr_last_q[HDR_BEATS-1] ? ST_CAPTURE : ST_DROP;
            end
         end
         ST_REPLAY: begin
            if (idx_q != REPLAY_DONE) begin
               if (out_free) begin
                  load_replay = 1'b1;
                  idx_d       = idx_q + 1'b1;
               end
            end else if (m_valid_q && m_axis_tready) begin
               idx_d   = '0;
               state_d = hdr_last_q[HDR_BEATS-1] ? ST_CAPTURE : ST_PASS;
            end
         end
         ST_PASS: begin
            s_ready_c = out_free;
            if (s_axis_tvalid && out_free) begin
               load_pass = 1'b1;
               if (s_axis_tlast) state_d = ST_CAPTURE;
            end
         end
         ST_DROP: begin
            s_ready_c = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_d = ST_CAPTURE;
         end
         default: state_d = ST_CAPTURE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_CAPTURE;
         idx_q     <= '0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (load_replay) begin
            m_data_q  <= hdr_data_q[idx_q];
            m_keep_q  <= hdr_keep_q[idx_q];
            m_last_q  <= hdr_last_q[idx_q];
            m_valid_q <= 1'b1;
         end else if (load_pass) begin
            m_data_q  <= s_axis_tdata;
            m_keep_q  <= s_axis_tkeep;
            m_last_q  <= s_axis_tlast;
            m_valid_q <= 1'b1;
         end else if (m_axis_tready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap_we) begin
         hdr_data_q[idx_q] <= s_axis_tdata;
         hdr_keep_q[idx_q] <= s_axis_tkeep;
         hdr_last_q[idx_q] <= s_axis_tlast;
      end
   end

   // Ready is forced low while reset is held, even though the state is already CAPTURE.
   assign s_axis_tready = rstn && s_ready_c;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;

`ifdef RX_FILTER_STATS_EN
   logic [31:0] pass_cnt_q, drop_cnt_q, runt_cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pass_cnt_q <= '0;
         drop_cnt_q <= '0;
         runt_cnt_q <= '0;
      end else begin
         if (pass_inc) pass_cnt_q <= pass_cnt_q + 32'd1;
         if (drop_inc) drop_cnt_q <= drop_cnt_q + 32'd1;
         if (runt_inc) runt_cnt_q <= runt_cnt_q + 32'd1;
      end
   end

   assign rx_pass_count = pass_cnt_q;
   assign rx_drop_count = drop_cnt_q;
   assign rx_runt_count = runt_cnt_q;
`else
   logic unused_stats;
   assign unused_stats  = ^{pass_inc, drop_inc, runt_inc};
   assign rx_pass_count = '0;
   assign rx_drop_count = '0;
   assign rx_runt_count = '0;
`endif

endmodule

// File: doc/ethernet_rx_frame_filter.md
Name: ethernet_rx_frame_filter

Overview:
Store-and-check filter placed directly upstream of ethernet_rx_parser, between the MAC RX AXI-Stream and the parser input. It buffers the first 6 beats (48 bytes, covering Eth+IPv4+UDP headers) of every frame and validates the headers. Accepted frames are replayed unchanged followed by the rest of the frame. Rejected or runt frames are discarded up to tlast, so the parser only sees well-formed IPv4/UDP frames addressed to this node.

Parameters:
DATA_WIDTH, 64, stream width; only 64 is supported.
LOCAL_MAC, 48'h02_00_00_00_00_01, unicast destination MAC accepted.
ACCEPT_BCAST, 1, also accept dst MAC FF:FF:FF:FF:FF:FF when 1.
UDP_DST_PORT, 16'd4791, required UDP destination port (RoCEv2).

Ports:
clk  in  1  system clock
rstn  in  1  reset; asynchronous assert, active-low
s_axis_tdata  in  64  frame data from MAC; byte 0 of each beat in [63:56]
s_axis_tkeep  in  8  byte enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of frame
m_axis_tdata  out  64  to ethernet_rx_parser
m_axis_tkeep  out  8  byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  parser ready
m_axis_tlast  out  1  end of frame
rx_pass_count  out  32  frames forwarded (stats)
rx_drop_count  out  32  frames rejected by header check (stats)
rx_runt_count  out  32  frames ending before beat 5 (stats)

Behaviour:
- Reset (async, rstn=0): state=CAPTURE, beat index=0, s_axis_tready=0, m_axis_tvalid/tlast=0, m_axis_tdata/tkeep=0, counters=0. Reset mid-frame abandons the frame. After reset, the first input beat is treated as beat 0.
- Byte offsets in frame -> beat n = offset/8. Fields checked: dst MAC bytes 0-5 (beat0[63:16]); EtherType bytes 12-13 (beat1[31:16]) == 16'h0800; version/IHL byte 14 (beat1[15:8]) == 8'h45; protocol byte 23 (beat2[7:0]) == 8'd17; UDP dst port bytes 36-37 (beat4[31:16]).
- CAPTURE: s_axis_tready=1. Each accepted beat is stored in hdr_buf[idx] with tdata, tkeep and tlast, and idx increments. If tlast arrives on beats 0-4: the frame is a runt. Increment rx_runt_count, reset idx to 0, stay in CAPTURE; nothing is output. When beat 5 is accepted -> DECIDE.
- DECIDE (1 cycle, tready=0): pass = mac_ok && type_ok && ver_ok && proto_ok && port_ok. Pass -> REPLAY with idx=0. Fail and the stored beat 5 has tlast -> CAPTURE, rx_drop_count+1. Fail otherwise -> DROP, rx_drop_count+1.
- REPLAY: s_axis_tready=0. Beats hdr_buf[0..5] are presented on m_axis in order, and the output register advances on m_axis_tready. After beat 5 handshakes: go to CAPTURE if its tlast was set, otherwise go to PASS. rx_pass_count increments on the final tlast handshake of the frame.
- PASS: single output register stage. s_axis_tready = !m_axis_tvalid || m_axis_tready. Data, tkeep and tlast are copied unchanged. Input tlast accepted -> CAPTURE. m_axis_tvalid is held until its handshake, and output data is stable while valid && !ready.
- DROP: s_axis_tready=1, m_axis_tvalid=0. Accepted tlast -> CAPTURE.
- Latency for an accepted frame: the first output beat is valid 2 cycles after beat 5 is accepted.
- Back-to-back frames: CAPTURE of the next frame begins the cycle after the previous tlast is accepted (PASS/DROP) or handshaken (REPLAY).
- AXI rules: tvalid never depends on tready. Gaps in s_axis_tvalid in any state simply stall. tkeep is not inspected.
- Counters wrap at 2^32.

Optional Feature:
RX_FILTER_STATS_EN. When defined, the three 32-bit counters are implemented as described. When undefined, the counter registers are not generated and rx_pass_count, rx_drop_count and rx_runt_count are tied to 32'd0. Filtering behaviour is identical in both builds.

Decomposition:
- Package rx_filter_pkg holds: ETHERTYPE_IPV4=16'h0800, IP_VER_IHL=8'h45, IP_PROTO_UDP=8'd17, HDR_BEATS=6, the field beat/bit positions, and the state encoding.
- One sub-module, rx_hdr_check, is natural: combinational field compare over hdr_buf producing pass and per-field ok flags, reusable by a later TX loopback checker.

Test Plan:
1. Valid 10-beat frame (dst=LOCAL_MAC, 0x0800, 0x45, proto 17, port 4791), m_axis_tready=1 -> identical 10 beats out, tlast on beat 9, rx_pass_count=1.
2. Same frame with EtherType 0x86DD -> no m_axis_tvalid, all 10 beats accepted, rx_drop_count=1.
3. 4-beat frame with tlast on beat 3 -> dropped, rx_runt_count=1. A following valid frame passes intact.
4. Broadcast dst with ACCEPT_BCAST=1 passes; UDP port 4792 -> dropped.
5. Valid 8-beat frame with m_axis_tready toggling 1/0 every cycle and random s_axis_tvalid gaps -> data/tkeep/tlast bit-exact and in order, and no beat is duplicated.
6. rstn pulsed low asynchronously mid-PASS -> outputs 0 immediately. The next frame is captured from beat 0 and passes.
